// File: rtl/wb_master_if.sv
// Bundle of CPU-side request/response and Wishbone classic signals for wb_master.
// The master modport is the view of the initiator; slave is the view of everything around it.
interface wb_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdata;
  logic        wb_ack;

  modport master (
    input  req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned,
    input  wb_rdata, wb_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned,
    output wb_rdata, wb_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb
  );
endinterface

// File: rtl/wb_master.sv
// Wishbone classic single-transfer initiator: one CPU load/store becomes one bus cycle,
// with lane steering, load alignment/extension, misalignment and timeout errors.
module wb_master #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  wb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [31:0]   wb_addr_q, wb_addr_d;
  logic [31:0]   wb_wdata_q, wb_wdata_d;
  logic [3:0]    wb_sel_q, wb_sel_d;
  logic          wb_we_q, wb_we_d;
  logic          wb_cyc_q, wb_cyc_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic          uns_q, uns_d;
  logic          accept;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'd0:    return {4{data[7:0]}};
      2'd1:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Bring the addressed lane down to bit 0, then sign- or zero-extend sub-word loads.
  function automatic logic [31:0] load_align(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign accept = bus.req_valid & req_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    wb_addr_d   = wb_addr_q;
    wb_wdata_d  = wb_wdata_q;
    wb_sel_d    = wb_sel_q;
    wb_we_d     = wb_we_q;
    wb_cyc_d    = wb_cyc_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;

    case (state_q)
      // IDLE and RESP both take requests so a transfer can start the cycle after a response
      IDLE, RESP: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
        if (accept) begin
          if (is_illegal(bus.req_size, bus.req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = BUS;
            req_ready_d = 1'b0;
            cnt_d       = '0;
            wb_addr_d   = {bus.req_addr[31:2], 2'b00};
            wb_wdata_d  = lane_wdata(bus.req_size, bus.req_wdata);
            wb_sel_d    = lane_sel(bus.req_size, bus.req_addr[1:0]);
            wb_we_d     = bus.req_we;
            wb_cyc_d    = 1'b1;
            size_d      = bus.req_size;
            off_d       = bus.req_addr[1:0];
            uns_d       = bus.req_unsigned;
          end
        end
      end
      // Ack takes priority over a timeout landing on the same edge
      BUS: begin
        req_ready_d = 1'b0;
        if (bus.wb_ack) begin
          state_d     = RESP;
          wb_cyc_d    = 1'b0;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wb_we_q ? 32'h0 : load_align(size_q, uns_q, off_q, bus.wb_rdata);
        end else begin
          cnt_d = cnt_q + TW'(1);
          if (cnt_q == LAST) begin
            state_d     = RESP;
            wb_cyc_d    = 1'b0;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        wb_cyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      wb_addr_q   <= 32'h0;
      wb_wdata_q  <= 32'h0;
      wb_sel_q    <= 4'h0;
      wb_we_q     <= 1'b0;
      wb_cyc_q    <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wb_addr_q   <= wb_addr_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_sel_q    <= wb_sel_d;
      wb_we_q     <= wb_we_d;
      wb_cyc_q    <= wb_cyc_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_wdata  = wb_wdata_q;
  assign bus.wb_sel    = wb_sel_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_cyc    = wb_cyc_q;
  assign bus.wb_stb    = wb_cyc_q;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: byte-array reference memory plus a wb_ram-like responder with
// programmable ack delay; directed scenarios followed by random transfers.
module tb_wb_master;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   ack_wait = 1;   // 0 = responder never acks

  wb_master_if bus ();

  wb_master #(.TIMEOUT(TO), .TW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] smem    [0:255];
  logic        s_ack;
  logic [31:0] s_rd;
  int          s_cnt;

  assign bus.wb_ack   = s_ack;
  assign bus.wb_rdata = s_rd;

  // Responder: registered ack after ack_wait edges of a live strobe
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ack <= 1'b0;
      s_cnt <= 0;
      s_rd  <= 32'h0;
    end else if (bus.wb_cyc && bus.wb_stb && !s_ack) begin
      if (ack_wait != 0 && s_cnt + 1 == ack_wait) begin
        s_ack <= 1'b1;
        s_cnt <= 0;
        if (bus.wb_we) begin
          for (int i = 0; i < 4; i++)
            if (bus.wb_sel[i]) smem[bus.wb_addr[9:2]][8*i +: 8] <= bus.wb_wdata[8*i +: 8];
        end else begin
          s_rd <= smem[bus.wb_addr[9:2]];
        end
      end else begin
        s_ack <= 1'b0;
        s_cnt <= s_cnt + 1;
      end
    end else begin
      s_ack <= 1'b0;
      s_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input logic uns);
    logic [31:0] v;
    int base;
    v = 32'h0;
    base = int'(a[9:0]);
    for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [31:0] a, input int nb);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(a[1:0]) && i < int'(a[1:0]) + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int nb);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [1:0] sz, input logic uns, output logic [31:0] rdata);
    int nb, t, n, cc, exp_cc;
    logic ill, got, stb_bad, exp_err, cap_we;
    logic [31:0] cap_addr, cap_wdata, exp_rd;
    logic [3:0] cap_sel;
    nb      = 1 << sz;
    ill     = (sz == 2'd3) || ((int'(a[1:0]) % nb) != 0);
    exp_err = ill || (ack_wait == 0);
    exp_cc  = ill ? 0 : ((ack_wait == 0) ? TO : ack_wait + 1);
    exp_rd  = (exp_err || we) ? 32'h0 : ref_load(a, nb, uns);
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_addr = a; bus.req_wdata = d; bus.req_we = we;
    bus.req_size = sz; bus.req_unsigned = uns; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0; cc = 0; got = 1'b0; stb_bad = 1'b0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_sel = 4'h0; cap_we = 1'b0;
    while (!got && n < TO + 20) begin
      @(negedge clk);
      n++;
      if (bus.wb_stb !== bus.wb_cyc) stb_bad = 1'b1;
      if (bus.wb_cyc) begin
        cc++;
        if (cc == 1) begin
          cap_addr = bus.wb_addr; cap_wdata = bus.wb_wdata;
          cap_sel = bus.wb_sel; cap_we = bus.wb_we;
        end
      end
      if (bus.rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("rsp_latency", 32'(n), 32'(ill ? 1 : exp_cc + 1));
    chk("cyc_cycles", 32'(cc), 32'(exp_cc));
    chk("stb_eq_cyc", 32'(stb_bad), 32'd0);
    if (!ill) begin
      chk("wb_addr", cap_addr, {a[31:2], 2'b00});
      chk("wb_sel", 32'(cap_sel), 32'(ref_sel(a, nb)));
      chk("wb_we", 32'(cap_we), 32'(we));
      if (we) chk("wb_wdata", cap_wdata, ref_wdata(d, nb));
    end
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("req_ready_at_rsp", 32'(bus.req_ready), 32'd1);
    rdata = bus.rsp_rdata;
    if (got && we && !exp_err)
      for (int i = 0; i < nb; i++) ref_mem[int'(a[9:0]) + i] = d[8*i +: 8];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, a, d;
    logic [1:0] sz;
    int pick;
    for (int w = 0; w < 256; w++) begin
      smem[w] = $urandom();
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = smem[w][8*b +: 8];
    end
    smem[4] = 32'hDEADBEEF;
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;

    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    reset_n = 1'b0;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("ready_low_until_edge", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(bus.req_ready), 32'd1);

    ack_wait = 1;
    do_req(32'h10, 32'h0, 1'b0, 2'd2, 1'b0, r);  chk("t1_word", r, 32'hDEADBEEF);
    do_req(32'h13, 32'hA5, 1'b1, 2'd0, 1'b0, r);
    do_req(32'h13, 32'h0, 1'b0, 2'd0, 1'b0, r);  chk("t2_sbyte", r, 32'hFFFFFFA5);
    do_req(32'h13, 32'h0, 1'b0, 2'd0, 1'b1, r);  chk("t2_ubyte", r, 32'h000000A5);
    do_req(32'h10, 32'h0, 1'b0, 2'd2, 1'b0, r);  chk("t2_word", r, 32'hA5ADBEEF);
    do_req(32'h12, 32'h8001, 1'b1, 2'd1, 1'b0, r);
    do_req(32'h12, 32'h0, 1'b0, 2'd1, 1'b0, r);  chk("t3_shalf", r, 32'hFFFF8001);
    do_req(32'h12, 32'h0, 1'b0, 2'd1, 1'b1, r);  chk("t3_uhalf", r, 32'h00008001);
    do_req(32'h102, 32'h0, 1'b0, 2'd2, 1'b0, r); chk("t4_misal_word", r, 32'h0);
    do_req(32'h101, 32'h0, 1'b0, 2'd1, 1'b0, r); chk("t4_misal_half", r, 32'h0);
    do_req(32'h0, 32'h0, 1'b0, 2'd3, 1'b0, r);   chk("t4_size3", r, 32'h0);
    ack_wait = 0;
    do_req(32'h10, 32'h0, 1'b0, 2'd2, 1'b0, r);  chk("t5_timeout", r, 32'h0);
    ack_wait = TO - 1;
    do_req(32'h10, 32'h0, 1'b0, 2'd2, 1'b0, r);  chk("t5_late_ack", r, 32'h8001BEEF);

    // Reset while a cycle is in flight
    ack_wait = 5;
    bus.req_addr = 32'h10; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_cyc_before", 32'(bus.wb_cyc), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_cyc", 32'(bus.wb_cyc), 32'd0);
    chk("t6_stb", 32'(bus.wb_stb), 32'd0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_req_ready", 32'(bus.req_ready), 32'd0);
    pick = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) pick++;
    end
    reset_n = 1'b1;
    #1 chk("t6_ready_wait_edge", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    if (bus.rsp_valid) pick++;
    chk("t6_no_response", 32'(pick), 32'd0);
    chk("t6_ready_after", 32'(bus.req_ready), 32'd1);
    ack_wait = 1;
    do_req(32'h10, 32'h0, 1'b0, 2'd2, 1'b0, r);  chk("t6_word_after", r, 32'h8001BEEF);

    for (int k = 0; k < 150; k++) begin
      pick = int'($urandom_range(0, 9));
      ack_wait = (pick == 0) ? 0 : (pick < 6) ? 1 : int'($urandom_range(2, TO - 1));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d  = $urandom();
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0 && sz == 2'd3) sz = 2'd2;
      do_req(a, d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_master.md
Name: wb_master

Overview:
Wishbone classic single-transfer initiator, the requesting end of the bus that the wb_ram responder serves.
- Converts a simple CPU-side load/store request (address, size, sign flag) into one Wishbone cycle.
- Generates byte selects, replicates write data across lanes, and aligns and extends read data.
- Flags misaligned accesses and bus timeouts as errors.
- Intended to sit between the Naive core's LSU/fetch logic and a wb_ram-style slave.

Parameters:
TIMEOUT, 255, cycles cyc/stb may stay high without ack before abort; legal range 2..2^TW-1
TW, 8, width of timeout counter

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block accepts request this cycle
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
req_we  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  input  1  zero-extend load (else sign-extend)
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  aligned/extended load data; 0 for stores and errors
rsp_err  output  1  misaligned, illegal size or timeout
wb_addr  output  32  word-aligned address {req_addr[31:2],2'b00}
wb_wdata  output  32  lane-replicated store data
wb_sel  output  4  byte lane enables
wb_we  output  1  write enable
wb_cyc  output  1  cycle
wb_stb  output  1  strobe
wb_rdata  input  32  slave read data
wb_ack  input  1  slave acknowledge

Behaviour:
Clock and reset:
- Single clock. reset_n is asynchronous and active-low.
- While reset_n=0: all outputs 0, including req_ready; state=IDLE; timeout counter=0.
- All outputs are registered.
- req_ready rises at the first clk edge after reset_n deasserts.
- Reset mid-transaction drops wb_cyc/wb_stb immediately (asynchronously); no response is produced.

States:
- IDLE: req_ready=1. Acceptance occurs at an edge where req_valid&req_ready.
  - Illegal request (size 3; half with addr[0]=1; word with addr[1:0]≠0): go to RESP with rsp_err=1, rsp_rdata=0. No bus cycle.
  - Legal request: latch request, drive wb_* and set cyc=stb=1 from the next cycle, clear counter, go to BUS. req_ready=0.
- BUS: hold wb_addr/wdata/sel/we/cyc/stb stable.
  - Edge with wb_ack=1: capture wb_rdata, cyc=stb=0 next cycle, go to RESP with err=0.
  - Edge without ack: increment counter. If counter==TIMEOUT-1 at that edge: drop cyc/stb, go to RESP with err=1, rdata=0.
  - Ack and timeout at the same edge: ack wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no rsp backpressure; the consumer must take the pulse.
- wb_ack outside BUS is ignored.

Lanes (o = addr[1:0]):
- sel:
  - byte: 4'b0001<<o
  - half: 4'b0011<<o
  - word: 4'b1111
- wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- rdata: shift wb_rdata right by 8*o.
  - byte/half: sign- or zero-extend from bit 7/15 per req_unsigned.
  - stores: rsp_rdata=0.

Timing:
- Zero-wait slave (ack registered one edge after stb, as wb_ram): acceptance edge E0 → cyc/stb high after E0 → ack seen at E2 → rsp_valid high E2..E3. cyc is high for exactly 2 cycles. Next acceptance is at E3, so minimum 3 cycles per transfer.
- Illegal request: rsp_valid high E0..E1.
- Timeout: cyc high exactly TIMEOUT cycles.

Test Plan:
1. Word load 0x10, mem[0x10..0x13]=EF BE AD DE → wb_addr=0x10, sel=1111, we=0, cyc high 2 cycles, rsp_valid 1 cycle at E2, rdata=0xDEADBEEF, err=0.
2. Byte store 0xA5 to 0x13 → wb_addr=0x10, sel=1000, wdata=0xA5A5A5A5. Then signed byte load 0x13 → 0xFFFFFFA5; unsigned → 0x000000A5; word load 0x10 → 0xA5ADBEEF.
3. Half store 0x8001 to 0x12 (sel=1100, wdata=0x80018001). Then signed half load 0x12 → 0xFFFF8001; unsigned → 0x00008001.
4. Word load 0x102, half load 0x101, size=3 at 0x0 → no cyc/stb ever, rsp_valid at E0..E1 with err=1, rdata=0; req_ready back high after.
5. TIMEOUT=16, slave never acks → cyc/stb high exactly 16 cycles, then rsp err=1, rdata=0. Repeat with ack on the 16th cycle → err=0 with valid data.
6. Assert reset_n=0 while cyc=1 → cyc/stb/rsp_valid/req_ready 0 immediately with no clock edge, no response. After release, req_ready=1 from the next edge, and a word load completes normally.
